// File: rtl/debug_memif_responder_pkg.sv
// -----------------------------------------------------------------------------
// debug_memif_responder_pkg
// Shared definitions for the debug memory-interface responder:
//   - issue FSM state encoding (RUN, WAIT_RD)
//   - request FIFO entry layout (62 bits) and its field offsets
//   - helper to pack a request into an entry
// -----------------------------------------------------------------------------
package debug_memif_responder_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_WAIT_RD = 1'b1
    } state_t;

    localparam int unsigned ENTRY_W   = 62;
    localparam int unsigned DATA_LSB  = 0;
    localparam int unsigned ADDR_LSB  = 32;
    localparam int unsigned MASK_LSB  = 57;
    localparam int unsigned RW_BIT    = 61;

    // Field order matches the offsets above (MSB first).
    typedef struct packed {
        logic        rw;
        logic [3:0]  mask;
        logic [24:0] addr;
        logic [31:0] data;
    } entry_t;

    function automatic entry_t pack_entry(
        input logic        rw,
        input logic [3:0]  mask,
        input logic [24:0] addr,
        input logic [31:0] data
    );
        entry_t e;
        e.rw   = rw;
        e.mask = mask;
        e.addr = addr;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/debug_memif_responder_if.sv
// -----------------------------------------------------------------------------
// debug_memif_responder_if
// Bundles the debug request channel and the memory-controller port.
//   slave  : responder view (debug_memif_responder)
//   master : environment view (debug initiator + memory controller)
// Debug side : iDEBUG_MEMIF_REQ_* in, oDEBUG_MEMIF_REQ_LOCK / oDEBUG_MEMIF_RD_* out
// Memory side: oMEM_* out, iMEM_BUSY / iMEM_RD_VALID / iMEM_RD_DATA in
// -----------------------------------------------------------------------------
interface debug_memif_responder_if;

    logic        iDEBUG_MEMIF_REQ_VALID;
    logic        iDEBUG_MEMIF_REQ_DQM0;
    logic        iDEBUG_MEMIF_REQ_DQM1;
    logic        iDEBUG_MEMIF_REQ_DQM2;
    logic        iDEBUG_MEMIF_REQ_DQM3;
    logic        iDEBUG_MEMIF_REQ_RW;
    logic [24:0] iDEBUG_MEMIF_REQ_ADDR;
    logic [31:0] iDEBUG_MEMIF_REQ_DATA;
    logic        oDEBUG_MEMIF_REQ_LOCK;
    logic        oDEBUG_MEMIF_RD_VALID;
    logic [31:0] oDEBUG_MEMIF_RD_DATA;

    logic        oMEM_REQ;
    logic        oMEM_RW;
    logic [3:0]  oMEM_MASK;
    logic [24:0] oMEM_ADDR;
    logic [31:0] oMEM_DATA;
    logic        iMEM_BUSY;
    logic        iMEM_RD_VALID;
    logic [31:0] iMEM_RD_DATA;

    modport slave (
        input  iDEBUG_MEMIF_REQ_VALID, iDEBUG_MEMIF_REQ_DQM0, iDEBUG_MEMIF_REQ_DQM1,
               iDEBUG_MEMIF_REQ_DQM2, iDEBUG_MEMIF_REQ_DQM3, iDEBUG_MEMIF_REQ_RW,
               iDEBUG_MEMIF_REQ_ADDR, iDEBUG_MEMIF_REQ_DATA,
               iMEM_BUSY, iMEM_RD_VALID, iMEM_RD_DATA,
        output oDEBUG_MEMIF_REQ_LOCK, oDEBUG_MEMIF_RD_VALID, oDEBUG_MEMIF_RD_DATA,
               oMEM_REQ, oMEM_RW, oMEM_MASK, oMEM_ADDR, oMEM_DATA
    );

    modport master (
        output iDEBUG_MEMIF_REQ_VALID, iDEBUG_MEMIF_REQ_DQM0, iDEBUG_MEMIF_REQ_DQM1,
               iDEBUG_MEMIF_REQ_DQM2, iDEBUG_MEMIF_REQ_DQM3, iDEBUG_MEMIF_REQ_RW,
               iDEBUG_MEMIF_REQ_ADDR, iDEBUG_MEMIF_REQ_DATA,
               iMEM_BUSY, iMEM_RD_VALID, iMEM_RD_DATA,
        input  oDEBUG_MEMIF_REQ_LOCK, oDEBUG_MEMIF_RD_VALID, oDEBUG_MEMIF_RD_DATA,
               oMEM_REQ, oMEM_RW, oMEM_MASK, oMEM_ADDR, oMEM_DATA
    );

endinterface

// File: rtl/debug_memif_req_fifo.sv
// -----------------------------------------------------------------------------
// debug_memif_req_fifo
// Synchronous request FIFO, FIFO_DEPTH entries (power of two), first-word
// fall-through: o_data always shows the head entry.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_push, i_data    write strobe / entry (ignored when full)
//   i_pop             remove head (ignored when empty)
//   o_data            head entry
//   o_full, o_empty   status
//   o_count           occupancy, FIFO_DEPTH_N+1 bits
// -----------------------------------------------------------------------------
module debug_memif_req_fifo
    import debug_memif_responder_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int FIFO_DEPTH_N = 2,
    parameter int W            = ENTRY_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [W-1:0]          i_data,
    input  logic                  i_pop,
    output logic [W-1:0]          o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [FIFO_DEPTH_N:0] o_count
);

    localparam logic [FIFO_DEPTH_N:0] FULL_CNT = (FIFO_DEPTH_N + 1)'(FIFO_DEPTH);

    logic [W-1:0]            r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH_N-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_N-1:0] r_rd_ptr;
    logic [FIFO_DEPTH_N:0]   r_count;
    logic                    w_do_push;
    logic                    w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage carries no reset; consumers qualify the head with o_empty.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers are FIFO_DEPTH_N bits wide, so they wrap modulo FIFO_DEPTH.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/debug_memif_responder.sv
// -----------------------------------------------------------------------------
// debug_memif_responder
// Target-side endpoint of the debug memory-interface request channel.
// Buffers byte-masked read/write requests in a FIFO and issues them in order
// to the memory controller; returns read data to the initiator. Backpressure
// uses LOCK = FIFO full || read pending (registered state only).
// Ports:
//   iCLOCK, iRESET  clock, asynchronous active-high reset
//   bus             debug_memif_responder_if.slave (request channel + memory port)
//   oERROR          sticky protocol-violation flag, cleared only by reset
// Build option:
//   DEBUG_MEMIF_RESPONDER_READ_EN  defined   -> full read path
//                                  undefined -> write-only; reads are dropped
//                                               at the FIFO input and flag oERROR
// -----------------------------------------------------------------------------
module debug_memif_responder
    import debug_memif_responder_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int FIFO_DEPTH_N = 2
) (
    input  logic                          iCLOCK,
    input  logic                          iRESET,
    debug_memif_responder_if.slave        bus,
    output logic                          oERROR
);

    entry_t                w_in;
    entry_t                w_head;
    logic [ENTRY_W-1:0]    w_fifo_dout;
    logic                  w_full;
    logic                  w_empty;
    logic [FIFO_DEPTH_N:0] w_count;
    logic                  w_lock;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_req;
    logic                  r_err;
    logic                  w_unused;

    assign w_in = pack_entry(bus.iDEBUG_MEMIF_REQ_RW,
                             {bus.iDEBUG_MEMIF_REQ_DQM0, bus.iDEBUG_MEMIF_REQ_DQM1,
                              bus.iDEBUG_MEMIF_REQ_DQM2, bus.iDEBUG_MEMIF_REQ_DQM3},
                             bus.iDEBUG_MEMIF_REQ_ADDR,
                             bus.iDEBUG_MEMIF_REQ_DATA);

    assign w_head   = w_fifo_dout;
    assign w_accept = bus.iDEBUG_MEMIF_REQ_VALID && !w_lock;
    assign w_pop    = w_req && !bus.iMEM_BUSY;

    debug_memif_req_fifo #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .FIFO_DEPTH_N (FIFO_DEPTH_N),
        .W            (ENTRY_W)
    ) u_fifo (
        .i_clk   (iCLOCK),
        .i_rst   (iRESET),
        .i_push  (w_push),
        .i_data  (w_in),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Memory-side fields read zero whenever no request is presented.
    assign bus.oMEM_REQ  = w_req;
    assign bus.oMEM_MASK = w_req ? w_head.mask : '0;
    assign bus.oMEM_ADDR = w_req ? w_head.addr : '0;
    assign bus.oMEM_DATA = w_req ? w_head.data : '0;
    assign bus.oDEBUG_MEMIF_REQ_LOCK = w_lock;
    assign oERROR = r_err;

`ifdef DEBUG_MEMIF_RESPONDER_READ_EN

    state_t      r_state;
    logic        r_rd_pending;
    logic        r_rd_valid;
    logic [31:0] r_rd_data;

    assign w_lock   = w_full || r_rd_pending;
    assign w_push   = w_accept;
    assign w_req    = (r_state == ST_RUN) && !w_empty;
    assign w_unused = ^w_count;

    assign bus.oMEM_RW               = w_req ? w_head.rw : 1'b0;
    assign bus.oDEBUG_MEMIF_RD_VALID = r_rd_valid;
    assign bus.oDEBUG_MEMIF_RD_DATA  = r_rd_data;

    // rd_pending drops on the edge that ends the RD_VALID pulse, so LOCK is
    // released one cycle after the pulse.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_state      <= ST_RUN;
            r_rd_pending <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;

            if (w_accept && !bus.iDEBUG_MEMIF_REQ_RW) begin
                r_rd_pending <= 1'b1;
            end else if (r_rd_valid) begin
                r_rd_pending <= 1'b0;
            end

            case (r_state)
                ST_RUN: begin
                    if (w_pop && !w_head.rw) begin
                        r_state <= ST_WAIT_RD;
                    end
                end
                ST_WAIT_RD: begin
                    if (bus.iMEM_RD_VALID) begin
                        r_rd_data  <= bus.iMEM_RD_DATA;
                        r_rd_valid <= 1'b1;
                        r_state    <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase

            if ((bus.iDEBUG_MEMIF_REQ_VALID && w_lock) ||
                (bus.iMEM_RD_VALID && (r_state != ST_WAIT_RD))) begin
                r_err <= 1'b1;
            end
        end
    end

`else

    assign w_lock   = w_full;
    assign w_push   = w_accept && bus.iDEBUG_MEMIF_REQ_RW;
    assign w_req    = !w_empty;
    assign w_unused = ^{w_count, w_head.rw, bus.iMEM_RD_DATA};

    assign bus.oMEM_RW               = 1'b1;
    assign bus.oDEBUG_MEMIF_RD_VALID = 1'b0;
    assign bus.oDEBUG_MEMIF_RD_DATA  = '0;

    // Write-only build: any read request or read return is a violation.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_err <= 1'b0;
        end else if ((bus.iDEBUG_MEMIF_REQ_VALID && w_lock) ||
                     (w_accept && !bus.iDEBUG_MEMIF_REQ_RW) ||
                     bus.iMEM_RD_VALID) begin
            r_err <= 1'b1;
        end
    end

`endif

endmodule

// File: tb/tb_debug_memif_responder.sv
module tb_debug_memif_responder;

`ifdef DEBUG_MEMIF_RESPONDER_READ_EN
    localparam logic RW_RST  = 1'b0;
    localparam logic LOCK_T5 = 1'b1;
`else
    localparam logic RW_RST  = 1'b1;
    localparam logic LOCK_T5 = 1'b0;
`endif

    logic clk;
    logic rst;
    logic err;
    int   n_assert;
    int   n_fail;

    debug_memif_responder_if bus ();

    debug_memif_responder #(
        .FIFO_DEPTH   (4),
        .FIFO_DEPTH_N (2)
    ) dut (
        .iCLOCK (clk),
        .iRESET (rst),
        .bus    (bus),
        .oERROR (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic put(input logic rw, input logic [3:0] dqm, input logic [24:0] addr,
                       input logic [31:0] data);
        bus.iDEBUG_MEMIF_REQ_VALID = 1'b1;
        bus.iDEBUG_MEMIF_REQ_RW    = rw;
        {bus.iDEBUG_MEMIF_REQ_DQM0, bus.iDEBUG_MEMIF_REQ_DQM1,
         bus.iDEBUG_MEMIF_REQ_DQM2, bus.iDEBUG_MEMIF_REQ_DQM3} = dqm;
        bus.iDEBUG_MEMIF_REQ_ADDR  = addr;
        bus.iDEBUG_MEMIF_REQ_DATA  = data;
    endtask

    task automatic idle();
        bus.iDEBUG_MEMIF_REQ_VALID = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.iDEBUG_MEMIF_REQ_VALID = 1'b0;
        bus.iDEBUG_MEMIF_REQ_RW    = 1'b0;
        bus.iDEBUG_MEMIF_REQ_DQM0  = 1'b0;
        bus.iDEBUG_MEMIF_REQ_DQM1  = 1'b0;
        bus.iDEBUG_MEMIF_REQ_DQM2  = 1'b0;
        bus.iDEBUG_MEMIF_REQ_DQM3  = 1'b0;
        bus.iDEBUG_MEMIF_REQ_ADDR  = '0;
        bus.iDEBUG_MEMIF_REQ_DATA  = '0;
        bus.iMEM_BUSY     = 1'b0;
        bus.iMEM_RD_VALID = 1'b0;
        bus.iMEM_RD_DATA  = '0;

        // Reset values
        tick(); tick();
        chk("rst_lock",    bus.oDEBUG_MEMIF_REQ_LOCK, 0);
        chk("rst_req",     bus.oMEM_REQ, 0);
        chk("rst_rw",      bus.oMEM_RW, RW_RST);
        chk("rst_mask",    bus.oMEM_MASK, 0);
        chk("rst_addr",    bus.oMEM_ADDR, 0);
        chk("rst_data",    bus.oMEM_DATA, 0);
        chk("rst_rdvalid", bus.oDEBUG_MEMIF_RD_VALID, 0);
        chk("rst_rddata",  bus.oDEBUG_MEMIF_RD_DATA, 0);
        chk("rst_err",     err, 0);
        rst = 1'b0;

        // Single write, memory idle
        put(1'b1, 4'h0, 25'h10, 32'hDEADBEEF);
        tick(); idle();
        chk("t1_req",  bus.oMEM_REQ, 1);
        chk("t1_rw",   bus.oMEM_RW, 1);
        chk("t1_mask", bus.oMEM_MASK, 0);
        chk("t1_addr", bus.oMEM_ADDR, 32'h10);
        chk("t1_data", bus.oMEM_DATA, 32'hDEADBEEF);
        chk("t1_lock", bus.oDEBUG_MEMIF_REQ_LOCK, 0);
        tick();
        chk("t1_drained", bus.oMEM_REQ, 0);

        // Fill FIFO under BUSY, then drain with a fifth write entering
        bus.iMEM_BUSY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            put(1'b1, 4'h0, 25'(i), 32'hA0 + 32'(i));
            tick();
            chk("t2_lock_fill", bus.oDEBUG_MEMIF_REQ_LOCK, (i == 3) ? 1 : 0);
        end
        idle();
        tick();
        chk("t2_hold_req",  bus.oMEM_REQ, 1);
        chk("t2_hold_addr", bus.oMEM_ADDR, 0);
        chk("t2_hold_data", bus.oMEM_DATA, 32'hA0);
        chk("t2_hold_lock", bus.oDEBUG_MEMIF_REQ_LOCK, 1);
        bus.iMEM_BUSY = 1'b0;
        tick();
        chk("t2_lock_rel", bus.oDEBUG_MEMIF_REQ_LOCK, 0);
        chk("t2_addr1",    bus.oMEM_ADDR, 1);
        put(1'b1, 4'h0, 25'h4, 32'hA4);
        tick(); idle();
        chk("t2_addr2", bus.oMEM_ADDR, 2);
        chk("t2_lock3", bus.oDEBUG_MEMIF_REQ_LOCK, 0);
        tick();
        chk("t2_addr3", bus.oMEM_ADDR, 3);
        chk("t2_data3", bus.oMEM_DATA, 32'hA3);
        tick();
        chk("t2_addr4", bus.oMEM_ADDR, 4);
        chk("t2_data4", bus.oMEM_DATA, 32'hA4);
        tick();
        chk("t2_empty", bus.oMEM_REQ, 0);
        chk("t2_err",   err, 0);

        // Byte masks
        put(1'b1, 4'b1010, 25'h55, 32'h11223344);
        tick(); idle();
        chk("t3_mask",  bus.oMEM_MASK, 4'b1010);
        chk("t3_addr",  bus.oMEM_ADDR, 32'h55);
        tick();
        put(1'b1, 4'hF, 25'h56, 32'h0);
        tick(); idle();
        chk("t3_fullmask_req",  bus.oMEM_REQ, 1);
        chk("t3_fullmask_mask", bus.oMEM_MASK, 4'hF);
        tick();
        chk("t3_empty", bus.oMEM_REQ, 0);

        // VALID while LOCK: dropped and flagged
        bus.iMEM_BUSY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            put(1'b1, 4'h0, 25'h30 + 25'(i), 32'(i));
            tick();
        end
        put(1'b1, 4'h0, 25'h3F, 32'hBAD);
        tick(); idle();
        chk("t4_err",  err, 1);
        chk("t4_lock", bus.oDEBUG_MEMIF_REQ_LOCK, 1);
        chk("t4_head", bus.oMEM_ADDR, 32'h30);
        bus.iMEM_BUSY = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("t4_drain_addr", bus.oMEM_ADDR, 32'h30 + 32'(i));
        end
        tick();
        chk("t4_no_extra", bus.oMEM_REQ, 0);
        chk("t4_err_held", err, 1);

        // Reset mid-operation
        bus.iMEM_BUSY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            put(1'b1, 4'h0, 25'h40 + 25'(i), 32'h40 + 32'(i));
            tick();
        end
        put(1'b0, 4'h0, 25'h43, 32'h0);
        tick(); idle();
        chk("t5_lock_before", bus.oDEBUG_MEMIF_REQ_LOCK, LOCK_T5);
        chk("t5_req_before",  bus.oMEM_REQ, 1);
        rst = 1'b1;
        #1;
        chk("t5_req",  bus.oMEM_REQ, 0);
        chk("t5_lock", bus.oDEBUG_MEMIF_REQ_LOCK, 0);
        chk("t5_err",  err, 0);
        chk("t5_addr", bus.oMEM_ADDR, 0);
        chk("t5_data", bus.oMEM_DATA, 0);
        chk("t5_mask", bus.oMEM_MASK, 0);
        chk("t5_rw",   bus.oMEM_RW, RW_RST);
        tick();
        rst = 1'b0;
        bus.iMEM_BUSY = 1'b0;
        put(1'b1, 4'h0, 25'h77, 32'h01020304);
        tick(); idle();
        chk("t5_new_req",  bus.oMEM_REQ, 1);
        chk("t5_new_addr", bus.oMEM_ADDR, 32'h77);
        chk("t5_new_data", bus.oMEM_DATA, 32'h01020304);
        tick();
        chk("t5_flushed", bus.oMEM_REQ, 0);
        chk("t5_err_ok",  err, 0);

        // Stray read return after reset
        bus.iMEM_RD_VALID = 1'b1;
        bus.iMEM_RD_DATA  = 32'hCAFEF00D;
        tick();
        bus.iMEM_RD_VALID = 1'b0;
        chk("t6_late_err",     err, 1);
        chk("t6_late_rdvalid", bus.oDEBUG_MEMIF_RD_VALID, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_err_clear", err, 0);

        // Read request
        put(1'b0, 4'h0, 25'h20, 32'h0);
        tick(); idle();
`ifdef DEBUG_MEMIF_RESPONDER_READ_EN
        chk("t7_lock_acc", bus.oDEBUG_MEMIF_REQ_LOCK, 1);
        chk("t7_req",      bus.oMEM_REQ, 1);
        chk("t7_rw",       bus.oMEM_RW, 0);
        chk("t7_addr",     bus.oMEM_ADDR, 32'h20);
        tick();
        chk("t7_wait_req",  bus.oMEM_REQ, 0);
        chk("t7_wait_lock", bus.oDEBUG_MEMIF_REQ_LOCK, 1);
        chk("t7_wait_rdv",  bus.oDEBUG_MEMIF_RD_VALID, 0);
        tick();
        bus.iMEM_RD_VALID = 1'b1;
        bus.iMEM_RD_DATA  = 32'h12345678;
        tick();
        bus.iMEM_RD_VALID = 1'b0;
        bus.iMEM_RD_DATA  = 32'h0;
        chk("t7_rdv",       bus.oDEBUG_MEMIF_RD_VALID, 1);
        chk("t7_rddata",    bus.oDEBUG_MEMIF_RD_DATA, 32'h12345678);
        chk("t7_lock_puls", bus.oDEBUG_MEMIF_REQ_LOCK, 1);
        tick();
        chk("t7_rdv_once",  bus.oDEBUG_MEMIF_RD_VALID, 0);
        chk("t7_lock_rel",  bus.oDEBUG_MEMIF_REQ_LOCK, 0);
        chk("t7_rddata_h",  bus.oDEBUG_MEMIF_RD_DATA, 32'h12345678);
        chk("t7_err",       err, 0);
`else
        chk("t7_req",  bus.oMEM_REQ, 0);
        chk("t7_err",  err, 1);
        chk("t7_lock", bus.oDEBUG_MEMIF_REQ_LOCK, 0);
        tick();
        chk("t7_no_issue", bus.oMEM_REQ, 0);
        chk("t7_rdv",      bus.oDEBUG_MEMIF_RD_VALID, 0);
        chk("t7_rddata",   bus.oDEBUG_MEMIF_RD_DATA, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
